// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parameterised serial sequence detector.
// Holds the length-field width helper, reset defaults and the overlap-mode enum.
package seq_det_pkg;

    localparam logic [31:0] DEF_RST_PATTERN = 32'h0000_000A;
    localparam int unsigned DEF_RST_LEN     = 4;

    typedef enum logic {
        MODE_NOOVL = 1'b0,
        MODE_OVL   = 1'b1
    } ovl_mode_e;

    // Width needed to hold a length value in the range 0..max_len inclusive.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a sticky saturation flag.
// A clear takes priority over a same-cycle increment.
module seq_match_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != ALL_ONES)) begin
            count <= count + ONE;
            if (count == (ALL_ONES - ONE)) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector: shifts qualified bits into a
// history register and compares the newest len bits against the stored pattern.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = DEF_RST_PATTERN[MAX_LEN-1:0],
    parameter int unsigned        RST_LEN     = DEF_RST_LEN,
    localparam int unsigned       LEN_W       = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               detect,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);
    localparam logic [LEN_W:0]   ONE_EXT   = (LEN_W + 1)'(1);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len_clamped;
    ovl_mode_e          overlap;
    logic               sample;
    logic               fill_ok;
    logic               match;

    assign sample          = enable & in_valid & ~cfg_we;
    assign hist_next       = {hist[MAX_LEN-2:0], in_bit};
    assign fill_next       = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
    assign fill_ok         = ({1'b0, fill} + ONE_EXT) >= {1'b0, len};
    assign cfg_len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
    end

    // Only the newest len bits take part in the compare; the rest are masked off.
    assign match = sample && (len != '0) && fill_ok &&
                   ((hist_next & len_mask) == (pattern & len_mask));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= RST_PATTERN;
            len     <= RST_LEN_L;
            overlap <= MODE_OVL;
            detect  <= 1'b0;
        end else if (cfg_we) begin
            pattern <= cfg_pattern;
            len     <= cfg_len_clamped;
            overlap <= ovl_mode_e'(cfg_overlap);
            hist    <= '0;
            fill    <= '0;
            detect  <= 1'b0;
        end else begin
            detect <= match;
            if (sample) begin
                hist <= hist_next;
                // Non-overlapping mode forces the next match to gather len fresh bits.
                fill <= (match && (overlap == MODE_NOOVL)) ? '0 : fill_next;
            end
        end
    end

    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (match),
        .clr  (clr_count),
        .count(match_count),
        .sat  (count_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a window-of-bits reference model
// predicts each clock edge; a monitor pops and compares on the falling edge.
module tb_seq_detector_param;

    localparam int          MAX_LEN   = 8;
    localparam int          LEN_W     = 4;
    localparam int          CNT_W     = 16;
    localparam int          SMALL_W   = 2;
    localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;
    localparam int unsigned CNT_MAX_S = (1 << SMALL_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               clr_count = 1'b0;
    logic               detect, detect_s;
    logic [CNT_W-1:0]   match_count;
    logic [SMALL_W-1:0] match_count_s;
    logic               count_sat, count_sat_s;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_bit(in_bit), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .detect(detect), .match_count(match_count), .count_sat(count_sat)
    );

    seq_detector_param #(.CNT_W(SMALL_W)) dut_small (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_bit(in_bit), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .detect(detect_s), .match_count(match_count_s), .count_sat(count_sat_s)
    );

    typedef struct {
        bit          det;
        int unsigned cnt;
        bit          sat;
        int unsigned cnt_s;
        bit          sat_s;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state: the bits received since the last clear/config/match-consume.
    bit          win[$];
    logic [7:0]  m_pat;
    int          m_len;
    bit          m_ovl;
    int unsigned m_cnt, m_cnt_s;
    bit          m_sat, m_sat_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_eval(output exp_t e);
        bit hit;
        hit = 1'b0;
        if (reset) begin
            win.delete();
            m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1'b1;
            m_cnt = 0; m_cnt_s = 0; m_sat = 1'b0; m_sat_s = 1'b0;
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_ovl = cfg_overlap;
                win.delete();
            end else if (enable && in_valid) begin
                win.push_back(in_bit);
                if (win.size() > MAX_LEN) void'(win.pop_front());
                if (m_len != 0 && win.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (win[win.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ovl) win.delete();
            end
            if (clr_count) begin
                m_cnt = 0; m_cnt_s = 0; m_sat = 1'b0; m_sat_s = 1'b0;
            end else if (hit) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_cnt == CNT_MAX) m_sat = 1'b1;
                if (m_cnt_s < CNT_MAX_S) m_cnt_s++;
                if (m_cnt_s == CNT_MAX_S) m_sat_s = 1'b1;
            end
        end
        e.det = hit; e.cnt = m_cnt; e.sat = m_sat; e.cnt_s = m_cnt_s; e.sat_s = m_sat_s;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        exp_t e;
        model_eval(e);
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic bit_in(input bit b, input bit v = 1'b1, input bit en = 1'b1, input bit clr = 1'b0);
        cfg_we = 1'b0; enable = en; in_valid = v; in_bit = b; clr_count = clr;
        tick();
        clr_count = 1'b0;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                             input bit v = 1'b0, input bit b = 1'b0);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        enable = 1'b1; in_valid = v; in_bit = b; clr_count = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic clear_counts();
        cfg_we = 1'b0; enable = 1'b1; in_valid = 1'b0; clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_detect", {31'd0, detect}, 32'd0);
        check("async_rst_count", {16'd0, match_count}, 32'd0);
        check("async_rst_sat", {31'd0, count_sat}, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    // Monitor: one prediction per clock edge, compared on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("detect", {31'd0, detect}, {31'd0, e.det});
                check("detect_small", {31'd0, detect_s}, {31'd0, e.det});
                check("count", {16'd0, match_count}, e.cnt);
                check("sat", {31'd0, count_sat}, {31'd0, e.sat});
                check("count_small", {30'd0, match_count_s}, e.cnt_s);
                check("sat_small", {31'd0, count_sat_s}, {31'd0, e.sat_s});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] s35;
        logic [7:0] p40;
        s35 = 8'b1010_1010;
        p40 = 8'b1011_0011;
        @(negedge clk);
        pulse_reset();

        // Default pattern 1010, overlapping: hits after bits 4, 6 and 8.
        for (int i = 0; i < 8; i++) begin
            bit_in(s35[7 - i]);
            check("ovl_detect", {31'd0, detect}, {31'd0, (i == 3 || i == 5 || i == 7)});
        end
        check("ovl_count", {16'd0, match_count}, 32'd3);

        // Non-overlapping: only bits 4 and 8 complete a match.
        configure(8'h0A, 4'd4, 1'b0);
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            bit_in(s35[7 - i]);
            check("noovl_detect", {31'd0, detect}, {31'd0, (i == 3 || i == 7)});
        end
        check("noovl_count", {16'd0, match_count}, 32'd2);

        // 111 with idle gaps between valid bits.
        configure(8'h07, 4'd3, 1'b1);
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1);
            bit_in(1'b0, 1'b0);
            check("gap_idle_detect", {31'd0, detect}, 32'd0);
        end
        check("gap_count", {16'd0, match_count}, 32'd4);

        // Saturation of the narrow counter, then clear racing a match.
        configure(8'h07, 4'd3, 1'b1);
        clear_counts();
        for (int i = 0; i < 7; i++) begin
            bit_in(1'b1);
            if (i == 3) check("sat_before_3rd", {31'd0, count_sat_s}, 32'd0);
            if (i == 4) check("sat_at_3rd", {31'd0, count_sat_s}, 32'd1);
        end
        check("sat_count_small", {30'd0, match_count_s}, 32'd3);
        check("sat_count_big", {16'd0, match_count}, 32'd5);
        bit_in(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_pri_count", {30'd0, match_count_s}, 32'd0);
        check("clr_pri_sat", {31'd0, count_sat_s}, 32'd0);
        check("clr_pri_detect", {31'd0, detect}, 32'd1);

        // Reset mid-sequence discards the partial 101.
        pulse_reset();
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        pulse_reset();
        bit_in(1'b0);
        check("post_rst_0", {31'd0, detect}, 32'd0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
        check("post_rst_hit", {31'd0, detect}, 32'd1);
        check("post_rst_count", {16'd0, match_count}, 32'd1);

        // cfg_len beyond MAX_LEN clamps to 8.
        configure(p40, 4'd12, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bit_in(p40[7 - i]);
            check("clamp_detect", {31'd0, detect}, {31'd0, (i == 7)});
        end

        // Zero length never matches.
        configure(8'h00, 4'd0, 1'b1);
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            bit_in(1'($urandom));
            check("len0_detect", {31'd0, detect}, 32'd0);
        end
        check("len0_count", {16'd0, match_count}, 32'd0);

        // A bit presented alongside cfg_we is discarded.
        configure(8'h03, 4'd2, 1'b1, 1'b1, 1'b1);
        bit_in(1'b1);
        check("cfg_drop_first", {31'd0, detect}, 32'd0);
        bit_in(1'b1);
        check("cfg_drop_second", {31'd0, detect}, 32'd1);

        // Hold with enable low: a would-be completing bit is ignored.
        bit_in(1'b1, 1'b1, 1'b0);
        check("disabled_detect", {31'd0, detect}, 32'd0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                configure(8'($urandom), 4'($urandom_range(0, 4)), 1'($urandom),
                          1'($urandom), 1'($urandom));
            end else if (r < 4) begin
                configure(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
            end else if (r < 5) begin
                pulse_reset();
            end else begin
                bit_in(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 49) == 0);
            end
        end

        enable = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
